half_gate: RTL and testbench

- 1-bit half adder with a purely combinational sum/carry path (outS, outC).
- Adds a registered copy of the result and saturating statistics counters for monitoring.
- Used as the leaf adder cell in the A3 arithmetic datapath; full adders and ripple adders are built from it.
- Combinational outputs never depend on clock or reset.

---
 rtl/half_gate.sv | 64 ++++++
 tb/tb_half_gate.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/half_gate.sv
// Leaf half adder: combinational sum/carry, a one-cycle registered copy, and
// saturating sum/carry event counters; there is no flow control to stall it.
module half_gate #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inA,
  input  logic             inB,
  input  logic             cnt_clr,
  output logic             outS,
  output logic             outC,
  output logic             outS_q,
  output logic             outC_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] sum_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] carry_cnt_q;
  logic [CNT_W-1:0] carry_cnt_d;
  logic [CNT_W-1:0] sum_cnt_q;
  logic [CNT_W-1:0] sum_cnt_d;

  // Pure gates: must stay valid with the clock stopped and reset held.
  assign outS = inA ^ inB;
  assign outC = inA & inB;

  always_comb begin
    carry_cnt_d = carry_cnt_q;
    sum_cnt_d   = sum_cnt_q;
    if (cnt_clr) begin
      carry_cnt_d = '0;
      sum_cnt_d   = '0;
    end else begin
      if (outC && (carry_cnt_q != CNT_MAX)) carry_cnt_d = carry_cnt_q + CNT_ONE;
      if (outS && (sum_cnt_q != CNT_MAX))   sum_cnt_d   = sum_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= 1'b0;
      carry_q     <= 1'b0;
      carry_cnt_q <= '0;
      sum_cnt_q   <= '0;
    end else begin
      sum_q       <= outS;
      carry_q     <= outC;
      carry_cnt_q <= carry_cnt_d;
      sum_cnt_q   <= sum_cnt_d;
    end
  end

  assign outS_q    = sum_q;
  assign outC_q    = carry_q;
  assign carry_cnt = carry_cnt_q;
  assign sum_cnt   = sum_cnt_q;

endmodule

// File: tb/tb_half_gate.sv
// Directed bench for half_gate: truth table, register latency, async reset,
// clear priority, saturation (CNT_W=2 instance) and mid-cycle glitches.
module tb_half_gate;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        inA;
  logic        inB;
  logic        cnt_clr;
  logic        outS;
  logic        outC;
  logic        outS_q;
  logic        outC_q;
  logic [15:0] carry_cnt;
  logic [15:0] sum_cnt;
  logic        s_outS;
  logic        s_outC;
  logic        s_outS_q;
  logic        s_outC_q;
  logic [1:0]  s_carry_cnt;
  logic [1:0]  s_sum_cnt;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic a;
    logic b;
    logic exp_s;
    logic exp_c;
  } vec_t;

  vec_t vecs [4];

  half_gate #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .inA(inA), .inB(inB), .cnt_clr(cnt_clr),
    .outS(outS), .outC(outC), .outS_q(outS_q), .outC_q(outC_q),
    .carry_cnt(carry_cnt), .sum_cnt(sum_cnt)
  );

  half_gate #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .inA(inA), .inB(inB), .cnt_clr(cnt_clr),
    .outS(s_outS), .outC(s_outC), .outS_q(s_outS_q), .outC_q(s_outC_q),
    .carry_cnt(s_carry_cnt), .sum_cnt(s_sum_cnt)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    clk_en    = 1'b0;
    rst_n     = 1'b0;
    inA       = 1'b0;
    inB       = 1'b0;
    cnt_clr   = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

    // Truth table with reset held and no clock running.
    #10;
    for (int i = 0; i < 4; i++) begin
      inA = vecs[i].a;
      inB = vecs[i].b;
      #100;
      chk($sformatf("tt_outS[%0d]", i), {31'd0, outS}, {31'd0, vecs[i].exp_s});
      chk($sformatf("tt_outC[%0d]", i), {31'd0, outC}, {31'd0, vecs[i].exp_c});
      chk($sformatf("tt_regs[%0d]", i), {14'd0, outS_q, outC_q, carry_cnt}, 32'd0);
      chk($sformatf("tt_sumcnt[%0d]", i), {16'd0, sum_cnt}, 32'd0);
    end

    // Release reset away from an edge, then check one-cycle latency.
    inA = 1'b0;
    inB = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    inA = 1'b1;
    inB = 1'b1;
    tick();
    chk("lat_outC_q", {31'd0, outC_q}, 32'd1);
    chk("lat_outS_q", {31'd0, outS_q}, 32'd0);
    chk("lat_carry_cnt", {16'd0, carry_cnt}, 32'd1);
    inA = 1'b1;
    inB = 1'b0;
    tick();
    chk("lat2_outS_q", {31'd0, outS_q}, 32'd1);
    chk("lat2_outC_q", {31'd0, outC_q}, 32'd0);
    chk("lat2_sum_cnt", {16'd0, sum_cnt}, 32'd1);

    // Build carry_cnt up to 5, then pulse reset between edges.
    inA = 1'b1;
    inB = 1'b1;
    repeat (4) tick();
    chk("pre_rst_carry_cnt", {16'd0, carry_cnt}, 32'd5);
    chk("pre_rst_outC_q", {31'd0, outC_q}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_regs", {14'd0, outS_q, outC_q, carry_cnt}, 32'd0);
    chk("arst_sum_cnt", {16'd0, sum_cnt}, 32'd0);
    chk("arst_outC", {31'd0, outC}, 32'd1);
    #1;
    rst_n = 1'b1;

    // Clear has priority over counting.
    cnt_clr = 1'b1;
    repeat (3) tick();
    chk("clr_carry_cnt", {16'd0, carry_cnt}, 32'd0);
    chk("clr_outC_q", {31'd0, outC_q}, 32'd1);
    cnt_clr = 1'b0;
    repeat (4) tick();
    chk("post_clr_carry_cnt", {16'd0, carry_cnt}, 32'd4);
    chk("post_clr_sum_cnt", {16'd0, sum_cnt}, 32'd0);
    chk("sat_carry_cnt", {30'd0, s_carry_cnt}, 32'd3);

    // Saturation on the 2-bit instance.
    inA = 1'b0;
    inB = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sat_sum_cnt[%0d]", i), {30'd0, s_sum_cnt}, (i < 2) ? i + 1 : 3);
    end
    chk("sat_wide_sum_cnt", {16'd0, sum_cnt}, 32'd6);

    // Glitch 00->11->00 entirely between two edges.
    inA = 1'b0;
    inB = 1'b0;
    tick();
    chk("gl_pre_outC_q", {31'd0, outC_q}, 32'd0);
    #1;
    inA = 1'b1;
    inB = 1'b1;
    #1;
    chk("gl_outC_high", {31'd0, outC}, 32'd1);
    inA = 1'b0;
    inB = 1'b0;
    #1;
    chk("gl_outC_low", {31'd0, outC}, 32'd0);
    tick();
    chk("gl_outC_q", {31'd0, outC_q}, 32'd0);
    chk("gl_carry_cnt", {16'd0, carry_cnt}, 32'd4);

    // Registered path across the whole table.
    for (int i = 0; i < 4; i++) begin
      inA = vecs[i].a;
      inB = vecs[i].b;
      tick();
      chk($sformatf("reg_outS_q[%0d]", i), {31'd0, outS_q}, {31'd0, vecs[i].exp_s});
      chk($sformatf("reg_outC_q[%0d]", i), {31'd0, outC_q}, {31'd0, vecs[i].exp_c});
    end
    chk("final_carry_cnt", {16'd0, carry_cnt}, 32'd5);
    chk("final_sum_cnt", {16'd0, sum_cnt}, 32'd8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
